// File: rtl/hart_sched_arbiter_pkg.sv
// Shared definitions for the hart scheduler arbiter: FSM state encoding
// and the width of the saturating switch counter.
package hart_sched_arbiter_pkg;
  localparam int CNT_W = 32;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_SWITCH = 2'd2
  } state_e;
endpackage

// File: rtl/hart_sched_arbiter_if.sv
// Bus between the per-hart core wrappers/cluster control and the hart
// scheduler arbiter.
//   master: drives hart status, hold, tick, quantum, interconnect busy
//   slave : the arbiter; returns selection, per-hart stall, switch pulse/count
interface hart_sched_arbiter_if #(
  parameter int N_HARTS = 2,
  parameter int QW      = 16,
  parameter int SEL_W   = $clog2(N_HARTS + 1)
);
  logic [N_HARTS-1:0] w_hart_active;
  logic [N_HARTS-1:0] w_irq_pending;
  logic [N_HARTS-1:0] w_switch_ok;
  logic               w_hold;
  logic               w_run_tick;
  logic [QW-1:0]      w_quantum;
  logic               w_interconnect_busy;
  logic [SEL_W-1:0]   r_hart_sel;
  logic [N_HARTS-1:0] w_core_busy;
  logic               w_switch;
  logic [31:0]        w_switch_count;

  modport master (
    output w_hart_active, w_irq_pending, w_switch_ok, w_hold, w_run_tick,
           w_quantum, w_interconnect_busy,
    input  r_hart_sel, w_core_busy, w_switch, w_switch_count
  );

  modport slave (
    input  w_hart_active, w_irq_pending, w_switch_ok, w_hold, w_run_tick,
           w_quantum, w_interconnect_busy,
    output r_hart_sel, w_core_busy, w_switch, w_switch_count
  );
endinterface

// File: rtl/hart_sched_arbiter_rr_pick.sv
// Combinational circular priority picker.
//   req   : request mask
//   base  : current index; scan order is base+1 .. base+N-1 (wrapping),
//           base itself is never picked
//   found : some request seen in that order
//   idx   : first requester in that order (base when none)
module rr_pick #(
  parameter int N     = 2,
  parameter int SEL_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] base,
  output logic             found,
  output logic [SEL_W-1:0] idx
);
  int p;

  // Scan from the far end so the nearest requester is written last and wins.
  always_comb begin
    found = 1'b0;
    idx   = base;
    p     = 0;
    for (int k = N - 1; k >= 1; k--) begin
      p = int'(base) + k;
      if (p >= N) p = p - N;
      if (req[p]) begin
        found = 1'b1;
        idx   = SEL_W'(p);
      end
    end
  end
endmodule

// File: rtl/hart_sched_arbiter.sv
// Time-slicing arbiter sharing one MMU/interconnect path among N_HARTS cores.
// Switches go RUN -> DRAIN -> SWITCH; the SWITCH cycle stalls every hart to
// give the MMU/TLB one clean cycle for context hand-over.
//   CLK, RST : clock, synchronous active-high reset
//   bus      : slave side of hart_sched_arbiter_if
module hart_sched_arbiter
  import hart_sched_arbiter_pkg::*;
#(
  parameter int N_HARTS = 2,
  parameter int QW      = 16,
  parameter int SEL_W   = $clog2(N_HARTS + 1)
) (
  input logic              CLK,
  input logic              RST,
  hart_sched_arbiter_if.slave bus
);
  state_e             state, state_nxt;
  logic [QW-1:0]      cnt, cnt_dec, q_load;
  logic [SEL_W-1:0]   sel, nxt_sel;
  logic [N_HARTS-1:0] sel_oh;
  logic [CNT_W-1:0]   sw_cnt;
  logic               cur_act, cur_irq, cur_ok, expired, req;
  logic               irq_found, act_found;
  logic [SEL_W-1:0]   irq_idx, act_idx;

  assign q_load = (bus.w_quantum == '0) ? QW'(1) : bus.w_quantum;

  always_comb begin
    sel_oh = '0;
    for (int g = 0; g < N_HARTS; g++) sel_oh[g] = (SEL_W'(g) == sel);
  end

  assign cur_act = |(bus.w_hart_active & sel_oh);
  assign cur_irq = |(bus.w_irq_pending & sel_oh);
  assign cur_ok  = |(bus.w_switch_ok & sel_oh);

  // Both pickers skip the current hart, so act_found doubles as
  // "a candidate exists" and irq_found as "another active hart has an irq".
  rr_pick #(.N(N_HARTS), .SEL_W(SEL_W)) u_pick_irq (
    .req  (bus.w_hart_active & bus.w_irq_pending),
    .base (sel),
    .found(irq_found),
    .idx  (irq_idx)
  );

  rr_pick #(.N(N_HARTS), .SEL_W(SEL_W)) u_pick_act (
    .req  (bus.w_hart_active),
    .base (sel),
    .found(act_found),
    .idx  (act_idx)
  );

  // Expiry looks at the post-tick value so a quantum of Q gives exactly
  // Q run cycles before draining starts.
  assign cnt_dec = (bus.w_run_tick && cnt != '0) ? cnt - QW'(1) : cnt;
  assign expired = (cnt_dec == '0);
  assign req     = act_found && (expired || !cur_act || (irq_found && !cur_irq));

  always_ff @(posedge CLK) begin
    if (RST) state <= ST_RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:    if (req && !bus.w_hold) state_nxt = ST_DRAIN;
      ST_DRAIN:  if (!req) state_nxt = ST_RUN;
                 else if (cur_ok && !bus.w_hold) state_nxt = ST_SWITCH;
      ST_SWITCH: state_nxt = ST_RUN;
      default:   state_nxt = ST_RUN;
    endcase
  end

  always_comb begin
    bus.w_core_busy = '1;
    bus.w_switch    = 1'b0;
    if (state == ST_SWITCH) bus.w_switch = 1'b1;
    else bus.w_core_busy = ~sel_oh | ({N_HARTS{bus.w_interconnect_busy}} & sel_oh);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sel     <= '0;
      nxt_sel <= '0;
      cnt     <= q_load;
      sw_cnt  <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          // Nobody to hand over to: start a fresh slice in place.
          if (expired && !act_found) cnt <= q_load;
          else                       cnt <= cnt_dec;
        end
        ST_DRAIN: begin
          cnt <= cnt_dec;
          if (state_nxt == ST_SWITCH) nxt_sel <= irq_found ? irq_idx : act_idx;
        end
        ST_SWITCH: begin
          sel <= nxt_sel;
          cnt <= q_load;
          if (sw_cnt != '1) sw_cnt <= sw_cnt + CNT_W'(1);
        end
        default: cnt <= q_load;
      endcase
    end
  end

  assign bus.r_hart_sel     = sel;
  assign bus.w_switch_count = sw_cnt;
endmodule

// File: tb/tb_hart_sched_arbiter.sv
module tb_hart_sched_arbiter;
  import hart_sched_arbiter_pkg::*;

  logic CLK = 1'b0;
  logic RST;
  int   checks = 0;
  int   failures = 0;

  always #5 CLK = ~CLK;

  hart_sched_arbiter_if #(.N_HARTS(2)) b2 ();
  hart_sched_arbiter_if #(.N_HARTS(4)) b4 ();

  hart_sched_arbiter #(.N_HARTS(2)) u2 (.CLK(CLK), .RST(RST), .bus(b2));
  hart_sched_arbiter #(.N_HARTS(4)) u4 (.CLK(CLK), .RST(RST), .bus(b4));

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    RST = 1'b1;
    b2.w_hart_active = 2'b11; b2.w_irq_pending = '0; b2.w_switch_ok = 2'b11;
    b2.w_hold = 1'b0; b2.w_run_tick = 1'b1; b2.w_quantum = 16'd0;
    b2.w_interconnect_busy = 1'b0;
    b4.w_hart_active = 4'b0000; b4.w_irq_pending = '0; b4.w_switch_ok = 4'b1111;
    b4.w_hold = 1'b0; b4.w_run_tick = 1'b1; b4.w_quantum = 16'd4;
    b4.w_interconnect_busy = 1'b0;

    // Reset state
    step(2);
    chk("rst_cnt_q0", 32'(u2.cnt), 32'd1);
    chk("rst_sel", 32'(b2.r_hart_sel), 32'd0);
    chk("rst_swcnt", b2.w_switch_count, 32'd0);
    chk("rst_switch", 32'(b2.w_switch), 32'd0);
    chk("rst_busy2", 32'(b2.w_core_busy), 32'b10);
    chk("rst_busy4", 32'(b4.w_core_busy), 32'b1110);
    b2.w_quantum = 16'd4;
    step(1);
    chk("rst_cnt_q4", 32'(u2.cnt), 32'd4);
    RST = 1'b0;

    // Test 1: N=2, quantum 4 -> switch every 6 cycles
    step(5);
    chk("t1_sw1", 32'(b2.w_switch), 32'd1);
    chk("t1_busy_sw", 32'(b2.w_core_busy), 32'b11);
    step(1);
    chk("t1_sel1", 32'(b2.r_hart_sel), 32'd1);
    chk("t1_cnt1", b2.w_switch_count, 32'd1);
    chk("t1_sw_off", 32'(b2.w_switch), 32'd0);
    step(5);
    chk("t1_sw2", 32'(b2.w_switch), 32'd1);
    step(1);
    chk("t1_sel0", 32'(b2.r_hart_sel), 32'd0);
    chk("t1_cnt2", b2.w_switch_count, 32'd2);
    step(6);
    chk("t1_sel1b", 32'(b2.r_hart_sel), 32'd1);
    chk("t1_cnt3", b2.w_switch_count, 32'd3);
    // N=4 with nobody active: never switches, counter keeps reloading
    chk("t6_inact_swcnt", b4.w_switch_count, 32'd0);
    chk("t6_inact_sel", 32'(b4.r_hart_sel), 32'd0);
    chk("t6_inact_cnt", 32'(u4.cnt), 32'd2);

    // Test 6: reset in the middle of SWITCH
    step(5);
    chk("t6_in_switch", 32'(b2.w_switch), 32'd1);
    chk("t6_sel_before", 32'(b2.r_hart_sel), 32'd1);
    RST = 1'b1;
    step(1);
    chk("t6_sel", 32'(b2.r_hart_sel), 32'd0);
    chk("t6_swcnt", b2.w_switch_count, 32'd0);
    chk("t6_state", 32'(u2.state), 32'(ST_RUN));
    chk("t6_switch", 32'(b2.w_switch), 32'd0);
    chk("t6_busy", 32'(b2.w_core_busy), 32'b10);

    // Test 2: N=4, active=1011, rotation 0->1->3->0
    b2.w_hart_active = 2'b00;
    b4.w_hart_active = 4'b1011; b4.w_quantum = 16'd2;
    step(1);
    RST = 1'b0;
    step(2);
    chk("t2_drain", 32'(u4.state), 32'(ST_DRAIN));
    step(2);
    chk("t2_sel1", 32'(b4.r_hart_sel), 32'd1);
    step(4);
    chk("t2_sel3", 32'(b4.r_hart_sel), 32'd3);
    step(4);
    chk("t2_sel0", 32'(b4.r_hart_sel), 32'd0);
    chk("t2_swcnt", b4.w_switch_count, 32'd3);

    // Test 3: irq preemption
    RST = 1'b1;
    b4.w_hart_active = 4'b1111; b4.w_quantum = 16'd100;
    b4.w_switch_ok = 4'b0000; b4.w_irq_pending = 4'b0000;
    step(1);
    RST = 1'b0;
    step(5);
    chk("t3_run", 32'(u4.state), 32'(ST_RUN));
    b4.w_irq_pending = 4'b0100;
    step(1);
    chk("t3_drain", 32'(u4.state), 32'(ST_DRAIN));
    step(3);
    chk("t3_drain_wait", 32'(u4.state), 32'(ST_DRAIN));
    b4.w_switch_ok = 4'b0001;
    step(1);
    chk("t3_switch", 32'(b4.w_switch), 32'd1);
    chk("t3_busy_sw", 32'(b4.w_core_busy), 32'b1111);
    step(1);
    chk("t3_sel2", 32'(b4.r_hart_sel), 32'd2);
    chk("t3_back_run", 32'(u4.state), 32'(ST_RUN));
    RST = 1'b1;
    b4.w_irq_pending = 4'b0000; b4.w_switch_ok = 4'b1111;
    step(1);
    RST = 1'b0;
    b4.w_irq_pending = 4'b0110;
    step(3);
    chk("t3_sel1_prio", 32'(b4.r_hart_sel), 32'd1);

    // Test 4: long drain waiting for switch_ok[0]
    RST = 1'b1;
    b4.w_irq_pending = 4'b0000; b4.w_switch_ok = 4'b0000; b4.w_quantum = 16'd3;
    step(1);
    RST = 1'b0;
    step(3);
    chk("t4_drain", 32'(u4.state), 32'(ST_DRAIN));
    step(10);
    chk("t4_drain10", 32'(u4.state), 32'(ST_DRAIN));
    chk("t4_busy_drain", 32'(b4.w_core_busy), 32'b1110);
    chk("t4_nosw", 32'(b4.w_switch), 32'd0);
    b4.w_switch_ok = 4'b0001;
    step(1);
    chk("t4_switch", 32'(b4.w_switch), 32'd1);
    chk("t4_busy_sw", 32'(b4.w_core_busy), 32'b1111);
    step(1);
    chk("t4_sw_off", 32'(b4.w_switch), 32'd0);
    chk("t4_busy_after", 32'(b4.w_core_busy), 32'b1101);

    // Test 5: hold with expired quantum
    RST = 1'b1;
    b4.w_switch_ok = 4'b1111; b4.w_quantum = 16'd2; b4.w_hold = 1'b1;
    step(1);
    RST = 1'b0;
    step(6);
    chk("t5_hold_state", 32'(u4.state), 32'(ST_RUN));
    chk("t5_hold_cnt", 32'(u4.cnt), 32'd0);
    chk("t5_hold_swcnt", b4.w_switch_count, 32'd0);
    b4.w_hold = 1'b0;
    step(1);
    chk("t5_drain", 32'(u4.state), 32'(ST_DRAIN));
    step(1);
    chk("t5_switch", 32'(u4.state), 32'(ST_SWITCH));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
